datapath_alu: RTL

DATAPATH_ALU -- requirements
Module: datapath_alu

---
 rtl/datapath_alu_if.sv | 20 ++
 rtl/datapath_alu.sv | 114 +++++++++++
 2 files changed

// File: rtl/datapath_alu_if.sv
// Request/writeback bundle between a sequencer and datapath_alu.
// The master drives the operation request; the slave returns status and writeback.
interface datapath_alu_if;
  logic       START;
  logic [2:0] OP;
  logic [2:0] DST;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       WB_LD;
  logic [2:0] WB_DR;
  logic [7:0] WB_DATA;
  logic       FLAG_Z;
  logic       FLAG_C;

  modport master (output START, OP, DST, A, B,
                  input  BUSY, WB_LD, WB_DR, WB_DATA, FLAG_Z, FLAG_C);
  modport slave  (input  START, OP, DST, A, B,
                  output BUSY, WB_LD, WB_DR, WB_DATA, FLAG_Z, FLAG_C);
endinterface

// File: rtl/datapath_alu.sv
// 8-bit ALU with register-file writeback: single-cycle logic/arith ops,
// 8-step shift-add multiply and restoring divide.
module datapath_alu (
  input  logic           CLK,
  input  logic           RESET,
  datapath_alu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic        is_div;
  logic [2:0]  dst_q, cnt;
  logic [7:0]  opa, opb;
  logic [15:0] acc;
  logic [2:0]  wb_dr;
  logic [7:0]  wb_data;
  logic        flag_z, flag_c;

  logic        start_ok, long_op, last_step;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic [15:0] mul_nxt, div_nxt, step_nxt;
  logic [8:0]  div_rs, div_sub;
  logic        div_ge;

  assign start_ok  = bus.START && (state == IDLE);
  assign long_op   = (bus.OP[2:1] == 2'b11);
  assign last_step = (state == EXEC) && (cnt == 3'd7);

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (bus.OP)
      3'b000:  {alu_c, alu_res} = {1'b0, bus.A} + {1'b0, bus.B};
      3'b001:  begin alu_res = bus.A - bus.B; alu_c = (bus.A < bus.B); end
      3'b010:  alu_res = bus.A & bus.B;
      3'b011:  alu_res = bus.A | bus.B;
      3'b100:  alu_res = bus.A ^ bus.B;
      3'b101:  begin alu_res = {bus.A[6:0], 1'b0}; alu_c = bus.A[7]; end
      default: ;
    endcase
  end

  // MUL: acc holds the partial product. DIV: acc = {remainder, quotient/dividend}.
  // A zero divisor makes every trial subtract succeed, so the quotient ends at 0xFF.
  assign mul_nxt  = acc + (opb[cnt] ? ({8'h00, opa} << cnt) : 16'h0000);
  assign div_rs   = {acc[15:8], acc[7]};
  assign div_ge   = (div_rs >= {1'b0, opb});
  assign div_sub  = div_rs - {1'b0, opb};
  assign div_nxt  = {div_ge ? div_sub[7:0] : div_rs[7:0], acc[6:0], div_ge};
  assign step_nxt = is_div ? div_nxt : mul_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = long_op ? EXEC : WB;
      EXEC:    if (cnt == 3'd7) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY  = (state != IDLE);
    bus.WB_LD = (state == WB);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      is_div  <= 1'b0;
      dst_q   <= 3'd0;
      opa     <= 8'h00;
      opb     <= 8'h00;
      acc     <= 16'h0000;
      cnt     <= 3'd0;
      wb_dr   <= 3'd0;
      wb_data <= 8'h00;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else if (start_ok) begin
      is_div <= (bus.OP == 3'b111);
      dst_q  <= bus.DST;
      opa    <= bus.A;
      opb    <= bus.B;
      acc    <= (bus.OP == 3'b111) ? {8'h00, bus.A} : 16'h0000;
      cnt    <= 3'd0;
      if (!long_op) begin
        wb_dr   <= bus.DST;
        wb_data <= alu_res;
        flag_z  <= (alu_res == 8'h00);
        flag_c  <= alu_c;
      end
    end else if (state == EXEC) begin
      acc <= step_nxt;
      cnt <= cnt + 3'd1;
      if (last_step) begin
        wb_dr   <= dst_q;
        wb_data <= step_nxt[7:0];
        flag_z  <= (step_nxt[7:0] == 8'h00);
        flag_c  <= is_div ? (opb == 8'h00) : (mul_nxt[15:8] != 8'h00);
      end
    end
  end

  assign bus.WB_DR   = wb_dr;
  assign bus.WB_DATA = wb_data;
  assign bus.FLAG_Z  = flag_z;
  assign bus.FLAG_C  = flag_c;
endmodule
